multicycle_ctrl: RTL

Control unit for the multicycle ARM-subset processor. It sequences a shared datapath (one memory, one ALU, IR/Data/ALUOut registers) through a Moore state machine, one instruction at a time. It owns the NZCV flags register and the condition check, and gates the register, memory and PC writes. It sits between the instruction register fields and the datapath mux/enable controls.

---
 rtl/multicycle_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Moore control unit for the multicycle ARM-subset core: state sequencing, NZCV flags, condition check.
// Optional MULTICYCLE_MEM_WAIT_EN adds a MemReady stall on FETCH/MEMRD/MEMWR.
module multicycle_ctrl #(
    parameter int FETCH_INC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
`ifdef MULTICYCLE_MEM_WAIT_EN
    input  logic       MemReady,
`endif
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic       MovOp,
    output logic       RegWrite
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECR   = 4'd6;
    localparam logic [3:0] S_EXECI   = 4'd7;
    localparam logic [3:0] S_ALUWB   = 4'd8;
    localparam logic [3:0] S_BRANCH  = 4'd9;
    localparam logic [3:0] S_UNKNOWN = 4'd10;

    // FETCH_INC is consumed by the datapath adder; reject nonsense at elaboration.
    if (FETCH_INC <= 0) begin : g_bad_inc
        $error("FETCH_INC must be positive");
    end

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [3:0] r_flags;
    logic       r_cond_ex;
    logic       w_cond_ex;
    logic       w_mem_ready;
    logic       w_alu_ok;
    logic [1:0] w_alu_ctl;
    logic       w_nowrite;
    logic       w_movop;
    logic       w_cv_upd;
    logic       w_flag_we;
    logic       w_execute;
    logic       w_rd_pc;
    logic       w_pcw;
    logic       w_memw;
    logic       w_irw;
    logic       w_regw;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign w_mem_ready = MemReady;
`else
    assign w_mem_ready = 1'b1;
`endif

    assign w_execute = (r_state == S_EXECR) || (r_state == S_EXECI);
    assign w_rd_pc   = (Rd == 4'd15);
    assign w_flag_we = w_execute & Funct[0] & r_cond_ex & w_alu_ok;

    always_comb begin
        w_alu_ok  = 1'b1;
        w_alu_ctl = 2'b00;
        w_nowrite = 1'b0;
        w_movop   = 1'b0;
        w_cv_upd  = 1'b0;
        case (Funct[4:1])
            4'b0100: w_cv_upd = 1'b1;
            4'b0010: begin
                w_alu_ctl = 2'b01;
                w_cv_upd  = 1'b1;
            end
            4'b0000: w_alu_ctl = 2'b10;
            4'b1100: w_alu_ctl = 2'b11;
            4'b1010: begin
                w_alu_ctl = 2'b01;
                w_nowrite = 1'b1;
                w_cv_upd  = 1'b1;
            end
            4'b1101: w_movop = 1'b1;
            default: begin
                w_alu_ok  = 1'b0;
                w_nowrite = 1'b1;
            end
        endcase
    end

    // Flags are {N,Z,C,V}.
    always_comb begin
        case (Cond)
            4'b0000: w_cond_ex = r_flags[2];
            4'b0001: w_cond_ex = ~r_flags[2];
            4'b0010: w_cond_ex = r_flags[1];
            4'b0011: w_cond_ex = ~r_flags[1];
            4'b0100: w_cond_ex = r_flags[3];
            4'b0101: w_cond_ex = ~r_flags[3];
            4'b0110: w_cond_ex = r_flags[0];
            4'b0111: w_cond_ex = ~r_flags[0];
            4'b1000: w_cond_ex = r_flags[1] & ~r_flags[2];
            4'b1001: w_cond_ex = ~r_flags[1] | r_flags[2];
            4'b1010: w_cond_ex = (r_flags[3] == r_flags[0]);
            4'b1011: w_cond_ex = (r_flags[3] != r_flags[0]);
            4'b1100: w_cond_ex = ~r_flags[2] & (r_flags[3] == r_flags[0]);
            4'b1101: w_cond_ex = r_flags[2] | (r_flags[3] != r_flags[0]);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (w_mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   w_next = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_UNKNOWN;
                endcase
            end
            S_MEMADR: w_next = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (w_mem_ready) w_next = S_MEMWB;
            S_MEMWR:  if (w_mem_ready) w_next = S_FETCH;
            S_EXECR:  w_next = S_ALUWB;
            S_EXECI:  w_next = S_ALUWB;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_flags   <= 4'b0000;
            r_cond_ex <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_cond_ex <= w_cond_ex;
            if (w_flag_we) begin
                r_flags[3:2] <= ALUFlags[3:2];
                if (w_cv_upd) r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        w_pcw      = 1'b0;
        w_memw     = 1'b0;
        w_irw      = 1'b0;
        w_regw     = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        MovOp      = 1'b0;
        ImmSrc     = Op;
        RegSrc     = {(Op == 2'b01) & ~Funct[0], (Op == 2'b10)};
        case (r_state)
            S_FETCH: begin
                w_irw     = w_mem_ready;
                w_pcw     = w_mem_ready;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                w_regw    = r_cond_ex;
                w_pcw     = r_cond_ex & w_rd_pc;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                w_memw = r_cond_ex & w_mem_ready;
            end
            S_EXECR: begin
                ALUControl = w_alu_ctl;
                MovOp      = w_movop;
            end
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_alu_ctl;
                MovOp      = w_movop;
            end
            S_ALUWB: begin
                w_regw = r_cond_ex & ~w_nowrite;
                w_pcw  = r_cond_ex & ~w_nowrite & w_rd_pc;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_pcw     = r_cond_ex;
            end
            default: ;
        endcase
    end

    assign PCWrite  = w_pcw & ~reset;
    assign MemWrite = w_memw & ~reset;
    assign IRWrite  = w_irw & ~reset;
    assign RegWrite = w_regw & ~reset;

endmodule
